axil_cfg_arb: RTL and testbench
===============================

AXIL_CFG_ARB -- requirements
Module: axil_cfg_arb

Interface
REQ-001 Parameter NUM_REQ, default 2, number of cfg-bus requesters (1..16).
REQ-002 Parameter ADDR_WIDTH, default 32, cfg address width.
REQ-003 Parameter DATA_WIDTH, default 32, cfg data width.
REQ-004 Parameter TIMEOUT_CYCLES, default 256, cycles to wait for target ack before aborting (>=2).
REQ-005 Parameter TIMEOUT_DATA, default 32'hDEAD_BEEF (DATA_WIDTH), rdata returned on timeout.
REQ-006 clk_i  input  1  single clock.
REQ-007 reset_i  input  1  asynchronous, active-high reset.
REQ-008 req_addr_i  input  NUM_REQ*ADDR_WIDTH  per-requester address, slot k at [k*ADDR_WIDTH +: ADDR_WIDTH].
REQ-009 req_wdata_i  input  NUM_REQ*DATA_WIDTH  per-requester write data.
REQ-010 req_wr_i  input  NUM_REQ  one-cycle write request pulse.
REQ-011 req_rd_i  input  NUM_REQ  one-cycle read request pulse.
REQ-012 req_ack_o  output  NUM_REQ  one-cycle completion pulse.
REQ-013 req_rdata_o  output  NUM_REQ*DATA_WIDTH  read data, valid with req_ack_o.
REQ-014 tgt_addr_o  output  ADDR_WIDTH  target address, held from issue until completion.
REQ-015 tgt_wdata_o  output  DATA_WIDTH  target write data, held likewise.
REQ-016 tgt_wr_o  output  1  one-cycle write pulse to target.
REQ-017 tgt_rd_o  output  1  one-cycle read pulse to target.
REQ-018 tgt_ack_i  input  1  target completion pulse.
REQ-019 tgt_rdata_i  input  DATA_WIDTH  target read data, valid with tgt_ack_i.
REQ-020 timeout_o  output  1  one-cycle pulse when a transaction is aborted by timeout.

Function
REQ-021 Each requester SHALL own a pending register (valid, op, addr, wdata) loaded at the edge after a req_wr_i/req_rd_i pulse.
REQ-022 Simultaneous req_wr_i and req_rd_i on one slot SHALL be captured as a write.
REQ-023 A request pulse on a slot whose pending valid is already set SHALL be dropped; the stored request is unchanged.
REQ-024 FSM states IDLE, ISSUE, WAIT; IDLE->ISSUE when any pending valid is set, grant chosen round-robin starting after the last granted slot (slot 0 first after reset).
REQ-025 In ISSUE, tgt_wr_o or tgt_rd_o SHALL be high for exactly one cycle with the granted addr/wdata; next state WAIT unless tgt_ack_i is high in the same cycle.
REQ-026 tgt_ack_i in ISSUE or WAIT SHALL complete the transaction: the next cycle, req_ack_o[grant]=1 for one cycle, req_rdata_o slot = captured tgt_rdata_i (writes also return the captured value), pending cleared, state IDLE.
REQ-027 A timeout counter SHALL clear on ISSUE entry and increment each ISSUE/WAIT cycle; reaching TIMEOUT_CYCLES without ack SHALL complete with rdata=TIMEOUT_DATA and pulse timeout_o with req_ack_o.
REQ-028 tgt_ack_i in the same cycle the counter expires SHALL win: normal completion, no timeout_o.
REQ-029 tgt_ack_i while IDLE (stray or late ack) SHALL be ignored.
REQ-030 A new pulse on the slot being completed in its req_ack_o cycle SHALL be captured as a fresh request.
REQ-031 Minimum latency: request pulse cycle N, target pulse cycle N+2, ack at cycle M gives req_ack_o at M+1; back-to-back grants need one IDLE cycle.

Reset
REQ-032 While reset_i is high all pending valids, req_ack_o, tgt_wr_o, tgt_rd_o, timeout_o SHALL be 0, tgt_addr_o/tgt_wdata_o/req_rdata_o 0, FSM IDLE, round-robin pointer to slot 0, counter 0.
REQ-033 Reset asserted mid-transaction SHALL abandon it with no ack to any requester; a target ack after reset release is ignored per REQ-029.

Structure
REQ-034 FSM state enum and default TIMEOUT_DATA constant SHALL live in the shared bus package.
REQ-035 Round-robin selection SHALL be one sub-module, cfg_rr_arb (NUM_REQ requests in, one-hot grant and index out, pointer advance input).

Verification
REQ-036 Single read: slot 0 rd addr 0x10, target acks 3 cycles after issue with 0x1234 -> req_ack_o[0] one cycle, rdata 0x1234, tgt_rd_o pulsed once.
REQ-037 Contention: slots 0,1 write same cycle -> slot 0 served first, slot 1 second, then new slot 0 and 1 requests served 1 then 0 order after 0 last granted... round-robin order verified over 8 transactions.
REQ-038 Timeout: TIMEOUT_CYCLES=8, no target ack -> req_ack_o and timeout_o 8 cycles after issue, rdata 0xDEADBEEF; late ack ignored.
REQ-039 Ack coincident with expiry -> target rdata returned, timeout_o stays 0.
REQ-040 Duplicate pulse on pending slot with different addr -> original addr issued, second dropped.
REQ-041 reset_i asserted in WAIT -> outputs zero asynchronously, no req_ack_o after release.

Source files
------------

// File: rtl/axil_cfg_arb_pkg.sv
// Shared definitions for the cfg-bus arbiter: FSM encoding, default abort data
// and a helper for index widths.
package axil_cfg_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_e;

  localparam logic [31:0] TIMEOUT_DATA_DEFAULT = 32'hDEAD_BEEF;

  // Width of an index into n slots; a single slot still gets one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cfg_rr_arb.sv
// Round-robin selector: searches from the slot after the last grant and
// remembers the winner when the caller advances.
module cfg_rr_arb
  import axil_cfg_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  localparam int unsigned IDX_W  = idx_width(NUM_REQ)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               adv_i,
  output logic [NUM_REQ-1:0] grant_c_o,
  output logic [IDX_W-1:0]   grant_idx_c_o,
  output logic               valid_c_o
);

  logic [IDX_W-1:0] last_q;
  logic [IDX_W-1:0] last_d;

  always_comb begin
    int unsigned      cand_sum;
    logic [IDX_W-1:0] cand;
    logic             found;
    grant_c_o     = '0;
    grant_idx_c_o = '0;
    found         = 1'b0;
    cand_sum      = 0;
    cand          = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand_sum = 32'(last_q) + i;
      if (cand_sum >= NUM_REQ) begin
        cand_sum = cand_sum - NUM_REQ;
      end
      cand = IDX_W'(cand_sum);
      if (!found && req_i[cand]) begin
        found           = 1'b1;
        grant_c_o[cand] = 1'b1;
        grant_idx_c_o   = cand;
      end
    end
    valid_c_o = found;
  end

  always_comb begin
    last_d = last_q;
    if (adv_i && valid_c_o) begin
      last_d = grant_idx_c_o;
    end
  end

  // Pointer starts on the last slot so slot 0 is searched first after reset.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      last_q <= IDX_W'(NUM_REQ - 1);
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/axil_cfg_arb.sv
// Arbitrates single-beat cfg-bus reads/writes from NUM_REQ requesters onto one
// target port, with per-requester pending slots and an ack timeout.
module axil_cfg_arb
  import axil_cfg_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA = DATA_WIDTH'(TIMEOUT_DATA_DEFAULT)
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [NUM_REQ-1:0]              req_wr_i,
  input  logic [NUM_REQ-1:0]              req_rd_i,
  output logic [NUM_REQ-1:0]              req_ack_o,
  output logic [NUM_REQ*DATA_WIDTH-1:0]   req_rdata_o,
  output logic [ADDR_WIDTH-1:0]           tgt_addr_o,
  output logic [DATA_WIDTH-1:0]           tgt_wdata_o,
  output logic                            tgt_wr_o,
  output logic                            tgt_rd_o,
  input  logic                            tgt_ack_i,
  input  logic [DATA_WIDTH-1:0]           tgt_rdata_i,
  output logic                            timeout_o
);

  localparam int unsigned IDX_W = idx_width(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_wdata;

  logic [NUM_REQ-1:0]                 pend_vld_q,   pend_vld_d;
  logic [NUM_REQ-1:0]                 pend_wr_q,    pend_wr_d;
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] pend_addr_q,  pend_addr_d;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] pend_wdata_q, pend_wdata_d;

  arb_state_e                         state_q,      state_d;
  logic [IDX_W-1:0]                   gnt_idx_q,    gnt_idx_d;
  logic [CNT_W-1:0]                   cnt_q,        cnt_d;
  logic [ADDR_WIDTH-1:0]              tgt_addr_q,   tgt_addr_d;
  logic [DATA_WIDTH-1:0]              tgt_wdata_q,  tgt_wdata_d;
  logic                               tgt_wr_q,     tgt_wr_d;
  logic                               tgt_rd_q,     tgt_rd_d;
  logic [NUM_REQ-1:0]                 req_ack_q,    req_ack_d;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_rdata_q,  req_rdata_d;
  logic                               timeout_q,    timeout_d;

  logic [NUM_REQ-1:0] arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_valid;
  logic               arb_adv;

  assign req_addr  = req_addr_i;
  assign req_wdata = req_wdata_i;

  cfg_rr_arb #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arb (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .req_i         (pend_vld_q),
    .adv_i         (arb_adv),
    .grant_c_o     (arb_grant),
    .grant_idx_c_o (arb_idx),
    .valid_c_o     (arb_valid)
  );

  always_comb begin
    logic                  cpl;
    logic [DATA_WIDTH-1:0] cpl_data;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  sel_wr;

    state_d      = state_q;
    gnt_idx_d    = gnt_idx_q;
    cnt_d        = cnt_q;
    tgt_addr_d   = tgt_addr_q;
    tgt_wdata_d  = tgt_wdata_q;
    tgt_wr_d     = 1'b0;
    tgt_rd_d     = 1'b0;
    req_ack_d    = '0;
    req_rdata_d  = req_rdata_q;
    timeout_d    = 1'b0;
    pend_vld_d   = pend_vld_q;
    pend_wr_d    = pend_wr_q;
    pend_addr_d  = pend_addr_q;
    pend_wdata_d = pend_wdata_q;
    arb_adv      = 1'b0;
    cpl          = 1'b0;
    cpl_data     = '0;
    sel_addr     = '0;
    sel_wdata    = '0;
    sel_wr       = 1'b0;

    // One-hot mux of the winning pending slot.
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (arb_grant[k]) begin
        sel_addr  = sel_addr  | pend_addr_q[k];
        sel_wdata = sel_wdata | pend_wdata_q[k];
        sel_wr    = sel_wr    | pend_wr_q[k];
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          state_d     = ST_ISSUE;
          arb_adv     = 1'b1;
          gnt_idx_d   = arb_idx;
          tgt_addr_d  = sel_addr;
          tgt_wdata_d = sel_wdata;
          tgt_wr_d    = sel_wr;
          tgt_rd_d    = !sel_wr;
          cnt_d       = '0;
        end
      end
      ST_ISSUE, ST_WAIT: begin
        state_d = ST_WAIT;
        cnt_d   = cnt_q + CNT_W'(1);
        // A target ack on the expiry cycle takes priority over the abort.
        if (tgt_ack_i) begin
          cpl      = 1'b1;
          cpl_data = tgt_rdata_i;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          cpl       = 1'b1;
          cpl_data  = TIMEOUT_DATA;
          timeout_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (cpl) begin
      state_d                = ST_IDLE;
      cnt_d                  = '0;
      req_ack_d[gnt_idx_q]   = 1'b1;
      req_rdata_d[gnt_idx_q] = cpl_data;
      pend_vld_d[gnt_idx_q]  = 1'b0;
    end

    // Capture new pulses only into free slots; write wins over read.
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!pend_vld_q[k] && (req_wr_i[k] || req_rd_i[k])) begin
        pend_vld_d[k]   = 1'b1;
        pend_wr_d[k]    = req_wr_i[k];
        pend_addr_d[k]  = req_addr[k];
        pend_wdata_d[k] = req_wdata[k];
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      gnt_idx_q    <= '0;
      cnt_q        <= '0;
      tgt_addr_q   <= '0;
      tgt_wdata_q  <= '0;
      tgt_wr_q     <= 1'b0;
      tgt_rd_q     <= 1'b0;
      req_ack_q    <= '0;
      req_rdata_q  <= '0;
      timeout_q    <= 1'b0;
      pend_vld_q   <= '0;
      pend_wr_q    <= '0;
      pend_addr_q  <= '0;
      pend_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      gnt_idx_q    <= gnt_idx_d;
      cnt_q        <= cnt_d;
      tgt_addr_q   <= tgt_addr_d;
      tgt_wdata_q  <= tgt_wdata_d;
      tgt_wr_q     <= tgt_wr_d;
      tgt_rd_q     <= tgt_rd_d;
      req_ack_q    <= req_ack_d;
      req_rdata_q  <= req_rdata_d;
      timeout_q    <= timeout_d;
      pend_vld_q   <= pend_vld_d;
      pend_wr_q    <= pend_wr_d;
      pend_addr_q  <= pend_addr_d;
      pend_wdata_q <= pend_wdata_d;
    end
  end

  assign req_ack_o   = req_ack_q;
  assign req_rdata_o = req_rdata_q;
  assign tgt_addr_o  = tgt_addr_q;
  assign tgt_wdata_o = tgt_wdata_q;
  assign tgt_wr_o    = tgt_wr_q;
  assign tgt_rd_o    = tgt_rd_q;
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_axil_cfg_arb.sv
// Bench for axil_cfg_arb: directed cycle-exact scenarios plus a randomized run
// against a transaction-level model of pending slots, round-robin and timeout.
module tb_axil_cfg_arb;

  localparam int NR = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic             clk = 1'b0;
  logic             reset_i;
  logic [NR*AW-1:0] req_addr_i;
  logic [NR*DW-1:0] req_wdata_i;
  logic [NR-1:0]    req_wr_i, req_rd_i, req_ack_o;
  logic [NR*DW-1:0] req_rdata_o;
  logic [AW-1:0]    tgt_addr_o;
  logic [DW-1:0]    tgt_wdata_o, tgt_rdata_i;
  logic             tgt_wr_o, tgt_rd_o, tgt_ack_i, timeout_o;

  int n_pass   = 0;
  int n_checks = 0;

  always #5 clk = ~clk;

  axil_cfg_arb #(
    .NUM_REQ        (NR),
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .req_addr_i  (req_addr_i),
    .req_wdata_i (req_wdata_i),
    .req_wr_i    (req_wr_i),
    .req_rd_i    (req_rd_i),
    .req_ack_o   (req_ack_o),
    .req_rdata_o (req_rdata_o),
    .tgt_addr_o  (tgt_addr_o),
    .tgt_wdata_o (tgt_wdata_o),
    .tgt_wr_o    (tgt_wr_o),
    .tgt_rd_o    (tgt_rd_o),
    .tgt_ack_i   (tgt_ack_i),
    .tgt_rdata_i (tgt_rdata_i),
    .timeout_o   (timeout_o)
  );

  task automatic clear_inputs();
    req_wr_i  = '0;
    req_rd_i  = '0;
    tgt_ack_i = 1'b0;
  endtask

  task automatic drive_req(input int k, input bit wr, input bit rd,
                           input logic [31:0] addr, input logic [31:0] wd);
    req_wr_i[k]             = wr;
    req_rd_i[k]             = rd;
    req_addr_i[k*AW +: AW]  = addr;
    req_wdata_i[k*DW +: DW] = wd;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_i = 1'b1;
    clear_inputs();
    repeat (3) @(negedge clk);
    reset_i = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_i     = 1'b1;
    clear_inputs();
    req_addr_i  = '1;
    req_wdata_i = '1;
    tgt_rdata_i = '0;
    drive_req(1, 1'b1, 1'b0, 32'h5, 32'h6);
    repeat (2) @(negedge clk);
    n_checks++; if (req_ack_o !== '0) $display("FAIL reset_ack: got %b want 0", req_ack_o); else n_pass++;
    n_checks++; if ({tgt_wr_o, tgt_rd_o, timeout_o} !== 3'b000) $display("FAIL reset_pulses: got %b want 000", {tgt_wr_o, tgt_rd_o, timeout_o}); else n_pass++;
    n_checks++; if (tgt_addr_o !== '0 || tgt_wdata_o !== '0) $display("FAIL reset_tgt_bus: got %h/%h want 0/0", tgt_addr_o, tgt_wdata_o); else n_pass++;
    n_checks++; if (req_rdata_o !== '0) $display("FAIL reset_rdata: got %h want 0", req_rdata_o); else n_pass++;
    clear_inputs();
    reset_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++; if ({tgt_wr_o, tgt_rd_o} !== 2'b00) $display("FAIL reset_no_issue: cyc %0d got %b want 00", c, {tgt_wr_o, tgt_rd_o}); else n_pass++;
    end
  endtask

  task automatic test_single_read();
    int rd_pulses = 0;
    do_reset();
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      clear_inputs();
      if (tgt_rd_o) rd_pulses++;
      if (c == 2) begin
        n_checks++; if (tgt_rd_o !== 1'b1 || tgt_wr_o !== 1'b0) $display("FAIL rd_issue: got rd=%b wr=%b want rd=1 wr=0", tgt_rd_o, tgt_wr_o); else n_pass++;
        n_checks++; if (tgt_addr_o !== 32'h10) $display("FAIL rd_addr: got %h want 00000010", tgt_addr_o); else n_pass++;
      end
      if (c == 6) begin
        n_checks++; if (req_ack_o !== 3'b001) $display("FAIL rd_ack: got %b want 001", req_ack_o); else n_pass++;
        n_checks++; if (req_rdata_o[0 +: DW] !== 32'h1234) $display("FAIL rd_data: got %h want 00001234", req_rdata_o[0 +: DW]); else n_pass++;
        n_checks++; if (timeout_o !== 1'b0) $display("FAIL rd_timeout: got %b want 0", timeout_o); else n_pass++;
      end else begin
        n_checks++; if (req_ack_o !== '0) $display("FAIL rd_ack_idle: cyc %0d got %b want 000", c, req_ack_o); else n_pass++;
      end
      if (c == 0) drive_req(0, 1'b0, 1'b1, 32'h10, 32'h0);
      if (c == 5) begin tgt_ack_i = 1'b1; tgt_rdata_i = 32'h1234; end
    end
    n_checks++; if (rd_pulses !== 1) $display("FAIL rd_pulse_count: got %0d want 1", rd_pulses); else n_pass++;
  endtask

  task automatic test_contention();
    logic [NR-1:0] masks [4] = '{3'b011, 3'b110, 3'b111, 3'b001};
    int exp_ord [8] = '{0, 1, 2, 1, 2, 0, 1, 0};
    int n = 0;
    do_reset();
    for (int r = 0; r < 4; r++) begin
      int want = 0;
      int seen = 0;
      @(negedge clk);
      clear_inputs();
      for (int k = 0; k < NR; k++) begin
        if (masks[r][k]) begin
          drive_req(k, 1'b1, 1'b0, 32'((k << 8) | r), 32'(k + 16 * r));
          want++;
        end
      end
      for (int t = 0; t < 40 && seen < want; t++) begin
        @(negedge clk);
        clear_inputs();
        if (tgt_wr_o) begin
          n_checks++;
          if (n >= 8) $display("FAIL rr_extra: got slot %0d want no grant", tgt_addr_o[9:8]);
          else if (32'(tgt_addr_o[9:8]) !== exp_ord[n]) $display("FAIL rr_order: txn %0d got slot %0d want %0d", n, tgt_addr_o[9:8], exp_ord[n]);
          else n_pass++;
          n++;
          seen++;
          tgt_ack_i = 1'b1;
        end
      end
      if (seen < want) begin
        n_checks++;
        $display("FAIL rr_wait: round %0d got %0d grants want %0d", r, seen, want);
      end
      @(negedge clk);
      clear_inputs();
      repeat (2) @(negedge clk);
    end
    n_checks++; if (n !== 8) $display("FAIL rr_count: got %0d want 8", n); else n_pass++;
  endtask

  task automatic test_timeout();
    do_reset();
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      clear_inputs();
      if (c == 2) begin
        n_checks++; if (tgt_rd_o !== 1'b1) $display("FAIL to_issue: got %b want 1", tgt_rd_o); else n_pass++;
      end
      if (c == 10) begin
        n_checks++; if (req_ack_o !== 3'b010) $display("FAIL to_ack: got %b want 010", req_ack_o); else n_pass++;
        n_checks++; if (timeout_o !== 1'b1) $display("FAIL to_pulse: got %b want 1", timeout_o); else n_pass++;
        n_checks++; if (req_rdata_o[DW +: DW] !== 32'hDEADBEEF) $display("FAIL to_data: got %h want deadbeef", req_rdata_o[DW +: DW]); else n_pass++;
      end else if (c > 2) begin
        n_checks++; if ({req_ack_o, timeout_o, tgt_rd_o} !== '0) $display("FAIL to_quiet: cyc %0d got ack=%b to=%b rd=%b want 0", c, req_ack_o, timeout_o, tgt_rd_o); else n_pass++;
      end
      if (c == 0) drive_req(1, 1'b0, 1'b1, 32'h20, 32'h0);
      if (c == 10) begin tgt_ack_i = 1'b1; tgt_rdata_i = 32'h5555_5555; end
    end
    n_checks++; if (req_rdata_o[DW +: DW] !== 32'hDEADBEEF) $display("FAIL to_late_ack: got %h want deadbeef", req_rdata_o[DW +: DW]); else n_pass++;
  endtask

  task automatic test_ack_at_expiry();
    do_reset();
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      clear_inputs();
      if (c == 10) begin
        n_checks++; if (req_ack_o !== 3'b100) $display("FAIL exp_ack: got %b want 100", req_ack_o); else n_pass++;
        n_checks++; if (timeout_o !== 1'b0) $display("FAIL exp_timeout: got %b want 0", timeout_o); else n_pass++;
        n_checks++; if (req_rdata_o[2*DW +: DW] !== 32'hCAFE0001) $display("FAIL exp_data: got %h want cafe0001", req_rdata_o[2*DW +: DW]); else n_pass++;
      end else if (c > 2) begin
        n_checks++; if ({req_ack_o, timeout_o} !== '0) $display("FAIL exp_quiet: cyc %0d got ack=%b to=%b want 0", c, req_ack_o, timeout_o); else n_pass++;
      end
      if (c == 0) drive_req(2, 1'b0, 1'b1, 32'h40, 32'h0);
      if (c == 9) begin tgt_ack_i = 1'b1; tgt_rdata_i = 32'hCAFE0001; end
    end
  endtask

  task automatic test_dup_drop();
    int wr_pulses = 0;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      clear_inputs();
      if (tgt_wr_o) wr_pulses++;
      if (c == 2) begin
        n_checks++; if (tgt_wr_o !== 1'b1 || tgt_addr_o !== 32'hA0) $display("FAIL dup_first: got wr=%b addr=%h want wr=1 addr=a0", tgt_wr_o, tgt_addr_o); else n_pass++;
        n_checks++; if (tgt_wdata_o !== 32'h111) $display("FAIL dup_wdata: got %h want 111", tgt_wdata_o); else n_pass++;
        tgt_ack_i = 1'b1; tgt_rdata_i = 32'h0BAD;
      end
      if (c == 3) begin
        n_checks++; if (req_ack_o !== 3'b001) $display("FAIL dup_ack: got %b want 001", req_ack_o); else n_pass++;
        n_checks++; if (req_rdata_o[0 +: DW] !== 32'h0BAD) $display("FAIL dup_wr_data: got %h want 00000bad", req_rdata_o[0 +: DW]); else n_pass++;
      end
      if (c == 4) begin
        n_checks++; if (tgt_wr_o !== 1'b0) $display("FAIL dup_gap: got %b want 0", tgt_wr_o); else n_pass++;
      end
      if (c == 5) begin
        n_checks++; if (tgt_wr_o !== 1'b1 || tgt_addr_o !== 32'hC0) $display("FAIL dup_refill: got wr=%b addr=%h want wr=1 addr=c0", tgt_wr_o, tgt_addr_o); else n_pass++;
        tgt_ack_i = 1'b1;
      end
      if (c == 0) drive_req(0, 1'b1, 1'b0, 32'hA0, 32'h111);
      if (c == 1) drive_req(0, 1'b1, 1'b0, 32'hB0, 32'h222);
      if (c == 3) drive_req(0, 1'b1, 1'b1, 32'hC0, 32'h333);
    end
    n_checks++; if (wr_pulses !== 2) $display("FAIL dup_count: got %0d want 2", wr_pulses); else n_pass++;
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      clear_inputs();
      if (c == 0) drive_req(0, 1'b0, 1'b1, 32'h77, 32'h0);
      if (c == 2) begin
        n_checks++; if (tgt_rd_o !== 1'b1 || tgt_addr_o !== 32'h77) $display("FAIL rst_issue: got rd=%b addr=%h want rd=1 addr=77", tgt_rd_o, tgt_addr_o); else n_pass++;
      end
      if (c == 4) begin
        #2 reset_i = 1'b1;
        #1;
        n_checks++; if (tgt_addr_o !== '0) $display("FAIL rst_async_addr: got %h want 0", tgt_addr_o); else n_pass++;
        n_checks++; if (req_rdata_o !== '0) $display("FAIL rst_async_rdata: got %h want 0", req_rdata_o); else n_pass++;
      end
      if (c >= 5) begin
        n_checks++; if ({req_ack_o, tgt_rd_o, tgt_wr_o, timeout_o} !== '0) $display("FAIL rst_quiet: cyc %0d got ack=%b rd=%b wr=%b to=%b want 0", c, req_ack_o, tgt_rd_o, tgt_wr_o, timeout_o); else n_pass++;
      end
      if (c == 6) reset_i = 1'b0;
      if (c == 7) begin tgt_ack_i = 1'b1; tgt_rdata_i = 32'h99; end
    end
  endtask

  // Transaction-level model: a pulse is stored only into a free slot and
  // becomes visible the next cycle; an issue follows one idle cycle in which
  // some slot was visible, picking round-robin after the last grant.
  task automatic test_random();
    bit          m_v [NR];
    bit          m_wr [NR];
    int          m_vfrom [NR];
    logic [31:0] m_addr [NR];
    logic [31:0] m_wd [NR];
    int          last = NR - 1;
    int          idle_from = -1;
    bit          busy = 1'b0;
    int          cur = 0, issue_cyc = 0, delay = 0, done_cyc = -1;
    bit          done_to = 1'b0;
    logic [31:0] done_data = '0;
    for (int k = 0; k < NR; k++) begin
      m_v[k] = 1'b0; m_wr[k] = 1'b0; m_vfrom[k] = 0; m_addr[k] = '0; m_wd[k] = '0;
    end
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      logic [NR-1:0] exp_ack = '0;
      bit            exp_to  = 1'b0;
      int            exp_s   = -1;
      @(negedge clk);
      clear_inputs();
      if (busy && c == done_cyc) begin
        exp_ack[cur] = 1'b1;
        exp_to       = done_to;
        busy         = 1'b0;
        m_v[cur]     = 1'b0;
        idle_from    = c;
      end
      n_checks++; if (req_ack_o !== exp_ack || timeout_o !== exp_to) $display("FAIL rnd_ack: cyc %0d got ack=%b to=%b want ack=%b to=%b", c, req_ack_o, timeout_o, exp_ack, exp_to); else n_pass++;
      if (exp_ack != '0) begin
        n_checks++; if (req_rdata_o[cur*DW +: DW] !== done_data) $display("FAIL rnd_rdata: cyc %0d slot %0d got %h want %h", c, cur, req_rdata_o[cur*DW +: DW], done_data); else n_pass++;
      end
      if (!busy && c - 1 >= idle_from) begin
        for (int i = 1; i <= NR; i++) begin
          int k = (last + i) % NR;
          if (exp_s < 0 && m_v[k] && m_vfrom[k] <= c - 1) exp_s = k;
        end
      end
      n_checks++; if ((tgt_wr_o | tgt_rd_o) !== (exp_s >= 0)) $display("FAIL rnd_issue: cyc %0d got wr=%b rd=%b want issue=%0d", c, tgt_wr_o, tgt_rd_o, exp_s >= 0); else n_pass++;
      if (exp_s >= 0) begin
        n_checks++; if (tgt_addr_o !== m_addr[exp_s] || tgt_wr_o !== m_wr[exp_s]) $display("FAIL rnd_txn: cyc %0d got addr=%h wr=%b want addr=%h wr=%b (slot %0d)", c, tgt_addr_o, tgt_wr_o, m_addr[exp_s], m_wr[exp_s], exp_s); else n_pass++;
        if (m_wr[exp_s]) begin
          n_checks++; if (tgt_wdata_o !== m_wd[exp_s]) $display("FAIL rnd_wdata: cyc %0d got %h want %h", c, tgt_wdata_o, m_wd[exp_s]); else n_pass++;
        end
        busy      = 1'b1;
        cur       = exp_s;
        last      = exp_s;
        issue_cyc = c;
        delay     = int'($urandom_range(0, 8));
        done_cyc  = -1;
      end
      tgt_rdata_i = $urandom;
      if (busy && done_cyc < 0) begin
        if (delay <= TO - 1 && c == issue_cyc + delay) begin
          tgt_ack_i = 1'b1;
          done_cyc  = c + 1;
          done_to   = 1'b0;
          done_data = tgt_rdata_i;
        end else if (c == issue_cyc + TO - 1) begin
          done_cyc  = c + 1;
          done_to   = 1'b1;
          done_data = 32'hDEADBEEF;
        end
      end else if (!busy && $urandom_range(0, 9) == 0) begin
        tgt_ack_i = 1'b1;
      end
      for (int k = 0; k < NR; k++) begin
        int unsigned r  = $urandom_range(0, 11);
        bit          wr = (r == 0) || (r == 2);
        bit          rd = (r == 1) || (r == 2);
        logic [31:0] a  = $urandom;
        logic [31:0] d  = $urandom;
        drive_req(k, wr, rd, a, d);
        if ((wr || rd) && !m_v[k]) begin
          m_v[k] = 1'b1; m_wr[k] = wr; m_vfrom[k] = c + 1; m_addr[k] = a; m_wd[k] = d;
        end
      end
    end
    @(negedge clk);
    clear_inputs();
  endtask

  initial begin
    reset_i     = 1'b1;
    req_addr_i  = '0;
    req_wdata_i = '0;
    tgt_rdata_i = '0;
    clear_inputs();
    test_reset();
    test_single_read();
    test_contention();
    test_timeout();
    test_dup_drop();
    test_ack_at_expiry();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
